// File: rtl/axi_lite_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_mem_pkg
// Brief    : Shared types and AXI response codes for the AXI-lite memory master.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } mem_master_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/AXI_ift.sv
`default_nettype none
// ============================================================================
// Module   : AXI_ift
// Brief    : AXI-lite channel bundle shared by the memory master and DDR slave.
// Revision : 1.0 - initial release
// ============================================================================
interface AXI_ift #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport Master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport Slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_mem_master
// Brief    : Single-outstanding CPU memory request to AXI-lite read/write bridge.
//            Optional debug state/visit counter: AXI_LITE_MEM_MASTER_DEBUG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_mem_master
    import axi_lite_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    AXI_ift.Master                  master_ift,
    output logic [2:0]              debug_state,
    output logic [31:0]             debug_visit_times
);

    mem_master_state_t r_state;
    mem_master_state_t w_state_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_arvalid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_err;

    logic w_accept, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic w_aw_done, w_w_done;
    logic w_req_ready, w_resp_valid, w_bready, w_rready;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_aw_hs  = r_awvalid && master_ift.awready;
    assign w_w_hs   = r_wvalid && master_ift.wready;
    assign w_ar_hs  = r_arvalid && master_ift.arready;
    assign w_b_hs   = w_bready && master_ift.bvalid;
    assign w_r_hs   = w_rready && master_ift.rvalid;
    // A dropped valid marks its channel as already handshaken
    assign w_aw_done = !r_awvalid || master_ift.awready;
    assign w_w_done  = !r_wvalid || master_ift.wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_bready     = 1'b0;
        w_rready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = req_wen ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (w_aw_done && w_w_done) begin
                    w_state_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                w_bready = 1'b1;
                if (master_ift.bvalid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (master_ift.arready) begin
                    w_state_next = ST_RDATA;
                end
            end
            ST_RDATA: begin
                w_rready = 1'b1;
                if (master_ift.rvalid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_resp_valid = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wmask;
                r_awvalid <= req_wen;
                r_wvalid  <= req_wen;
                r_arvalid <= !req_wen;
            end else begin
                if (w_aw_hs) r_awvalid <= 1'b0;
                if (w_w_hs)  r_wvalid  <= 1'b0;
                if (w_ar_hs) r_arvalid <= 1'b0;
            end
            if (w_b_hs) begin
                r_resp_err <= (master_ift.bresp != AXI_RESP_OKAY);
            end
            if (w_r_hs) begin
                r_resp_rdata <= master_ift.rdata;
                r_resp_err   <= (master_ift.rresp != AXI_RESP_OKAY);
            end
        end
    end

    assign req_ready          = w_req_ready;
    assign resp_valid         = w_resp_valid;
    assign resp_rdata         = r_resp_rdata;
    assign resp_err           = r_resp_err;

    assign master_ift.awaddr  = r_addr;
    assign master_ift.awprot  = 3'd0;
    assign master_ift.awvalid = r_awvalid;
    assign master_ift.wdata   = r_wdata;
    assign master_ift.wstrb   = r_wstrb;
    assign master_ift.wvalid  = r_wvalid;
    assign master_ift.bready  = w_bready;
    assign master_ift.araddr  = r_addr;
    assign master_ift.arprot  = 3'd0;
    assign master_ift.arvalid = r_arvalid;
    assign master_ift.rready  = w_rready;

`ifdef AXI_LITE_MEM_MASTER_DEBUG_EN
    logic [31:0] r_visit_times;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_visit_times <= 32'd0;
        end else if (r_state == ST_DONE) begin
            r_visit_times <= r_visit_times + 32'd1;
        end
    end

    assign debug_state       = r_state;
    assign debug_visit_times = r_visit_times;
`else
    assign debug_state       = 3'd0;
    assign debug_visit_times = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_mem_master
// Brief    : Self-checking bench: directed vector table, reset abort sequence,
//            and randomized traffic against a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_mem_master;
    import axi_lite_mem_pkg::*;

`ifdef AXI_LITE_MEM_MASTER_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [2:0]  debug_state;
    logic [31:0] debug_visit_times;

    always #5 clk = ~clk;

    AXI_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) axi ();

    axi_lite_mem_master #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wen           (req_wen),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wmask         (req_wmask),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .master_ift        (axi),
        .debug_state       (debug_state),
        .debug_visit_times (debug_visit_times)
    );

    function automatic logic [63:0] init_word(input int i);
        if (i == 0)  return 64'h1122_3344_5566_7788;
        if (i == 32) return 64'h0123_4567_89AB_CDEF;
        return {32'(i) ^ 32'hA5A5_0000, 32'(i * 7)};
    endfunction

    // ---------------- slave with per-channel wait knobs ----------------
    int  aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit  wr_err = 1'b0, rd_err = 1'b0;
    int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, mem_init = 1'b0;
    logic [63:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [7:0]  s_wstrb = '0;
    logic [63:0] mem [0:255];
    int  w_beats = 0, aw_hi = 0, w_hi = 0, ar_hi = 0, resp_cnt = 0;

    assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_wait);
    assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_wait);
    assign axi.bvalid  = aw_got && w_got && (b_cnt >= b_wait);
    assign axi.bresp   = wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign axi.arready = axi.arvalid && !ar_got && (ar_cnt >= ar_wait);
    assign axi.rvalid  = ar_got && (r_cnt >= r_wait);
    assign axi.rdata   = mem[s_araddr[10:3]];
    assign axi.rresp   = rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                mem_init <= 1'b1;
            end
        end else begin
            if (axi.awvalid && !axi.awready && !aw_got) aw_cnt <= aw_cnt + 1;
            if (axi.awready) begin
                aw_got <= 1'b1; s_awaddr <= axi.awaddr; aw_cnt <= 0;
            end
            if (axi.wvalid && !axi.wready && !w_got) w_cnt <= w_cnt + 1;
            if (axi.wready) begin
                w_got <= 1'b1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb;
                w_cnt <= 0; w_beats <= w_beats + 1;
            end
            if (aw_got && w_got) begin
                if (axi.bvalid && axi.bready) begin
                    aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                    if (!wr_err) begin
                        for (int b = 0; b < 8; b++)
                            if (s_wstrb[b]) mem[s_awaddr[10:3]][8*b +: 8] <= s_wdata[8*b +: 8];
                    end
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (axi.arvalid && !axi.arready && !ar_got) ar_cnt <= ar_cnt + 1;
            if (axi.arready) begin
                ar_got <= 1'b1; s_araddr <= axi.araddr; ar_cnt <= 0;
            end
            if (ar_got) begin
                if (axi.rvalid && axi.rready) begin
                    ar_got <= 1'b0; r_cnt <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (axi.awvalid) aw_hi <= aw_hi + 1;
        if (axi.wvalid)  w_hi  <= w_hi + 1;
        if (axi.arvalid) ar_hi <= ar_hi + 1;
        if (resp_valid)  resp_cnt <= resp_cnt + 1;
    end

    // ---------------- reference model and checking ----------------
    logic [7:0] ref_mem [0:2047];
    int n_checks = 0, n_fail = 0, n_done = 0;

    typedef struct {
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          aw_w, w_w, b_w, ar_w, r_w;
        bit          err;
        int          exp_lat;
        logic [63:0] exp_rdata;
        bit          exp_err;
        bit          chk_rdata;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [63:0] ref_read(input logic [63:0] addr);
        logic [63:0] r;
        int a;
        a = int'(addr[10:0]);
        for (int b = 0; b < 8; b++) r[8*b +: 8] = ref_mem[a + b];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int cyc, aw0, w0, ar0, beats0;
        aw_wait = v.aw_w; w_wait = v.w_w; b_wait = v.b_w;
        ar_wait = v.ar_w; r_wait = v.r_w;
        wr_err  = v.err;  rd_err = v.err;
        aw0 = aw_hi; w0 = w_hi; ar0 = ar_hi; beats0 = w_beats;
        check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
        req_wdata = v.wdata; req_wmask = v.wmask;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(v.exp_lat));
        check({tag, " resp_err"}, 64'(resp_err), 64'(v.exp_err));
        if (v.chk_rdata) check({tag, " rdata"}, resp_rdata, v.exp_rdata);
        check({tag, " debug_state done"}, 64'(debug_state), DBG ? 64'd5 : 64'd0);
        if (v.wen) begin
            check({tag, " w beats"}, 64'(w_beats - beats0), 64'd1);
            check({tag, " awvalid cycles"}, 64'(aw_hi - aw0), 64'(1 + v.aw_w));
            check({tag, " wvalid cycles"}, 64'(w_hi - w0), 64'(1 + v.w_w));
            if (!v.err) begin
                for (int b = 0; b < 8; b++)
                    if (v.wmask[b]) ref_mem[int'(v.addr[10:0]) + b] = v.wdata[8*b +: 8];
            end
        end else begin
            check({tag, " arvalid cycles"}, 64'(ar_hi - ar0), 64'(1 + v.ar_w));
        end
        n_done++;
        @(posedge clk); #1;
        check({tag, " resp pulse width"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int rc0;
        vec_t v;
        logic [63:0] w;

        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
        end

        //            wen addr        wdata                   mask  aw w b ar r err lat rdata                  err chk
        vecs[0] = '{1'b0, 64'h0,   64'h0,                 8'h00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h1122334455667788, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 64'h100, 64'hDEADBEEF_CAFEF00D, 8'h0F, 0, 0, 0, 0, 0, 1'b0, 3, 64'h0,                1'b0, 1'b0};
        vecs[2] = '{1'b0, 64'h100, 64'h0,                 8'h00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h01234567_CAFEF00D, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 64'h108, 64'h55AA_1234_8765_AA55, 8'hFF, 3, 0, 0, 0, 0, 1'b0, 6, 64'h0,              1'b0, 1'b0};
        vecs[4] = '{1'b0, 64'h108, 64'h0,                 8'h00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h55AA_1234_8765_AA55, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 64'h0,   64'h0,                 8'h00, 0, 0, 0, 0, 0, 1'b1, 3, 64'h1122334455667788, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 64'h0,   64'h0,                 8'h00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h1122334455667788, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 64'h110, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 0, 2, 1, 0, 0, 1'b1, 6, 64'h0,              1'b1, 1'b0};
        vecs[8] = '{1'b0, 64'h110, 64'h0,                 8'h00, 0, 0, 0, 1, 2, 1'b0, 6, 64'hA5A50022_000000EE, 1'b0, 1'b1};

        @(posedge clk); #1;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);
        check("reset resp_err", 64'(resp_err), 64'd0);
        check("reset valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
        check("reset debug", 64'({debug_state, debug_visit_times}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) run_op(vecs[k], $sformatf("vec%0d", k));
        check("debug visits after table", 64'(debug_visit_times), DBG ? 64'(n_done) : 64'd0);

        // Abort a read while it sits in the data phase
        ar_wait = 0; r_wait = 6; rd_err = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort rready before rst", 64'(axi.rready), 64'd1);
        rc0 = resp_cnt;
        rst = 1'b1;
        #1;
        check("abort valids low", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
        check("abort req_ready", 64'(req_ready), 64'd1);
        check("abort resp_rdata cleared", resp_rdata, 64'd0);
        check("abort debug", 64'({debug_state, debug_visit_times}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (8) @(posedge clk);
        #1;
        check("abort no resp pulse", 64'(resp_cnt - rc0), 64'd0);
        v = '{1'b0, 64'h100, 64'h0, 8'h00, 0, 0, 0, 0, 0, 1'b0, 3, ref_read(64'h100), 1'b0, 1'b1};
        run_op(v, "post-abort read");

        for (int k = 0; k < 24; k++) begin
            v.wen   = ($urandom_range(0, 1) == 1);
            v.addr  = 64'($urandom_range(0, 255)) << 3;
            v.wdata = {$urandom(), $urandom()};
            v.wmask = 8'($urandom_range(0, 255));
            v.aw_w  = $urandom_range(0, 3);
            v.w_w   = $urandom_range(0, 3);
            v.b_w   = $urandom_range(0, 3);
            v.ar_w  = $urandom_range(0, 3);
            v.r_w   = $urandom_range(0, 3);
            v.err   = ($urandom_range(0, 3) == 0);
            v.exp_lat   = v.wen ? 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w
                                : 3 + v.ar_w + v.r_w;
            v.exp_err   = v.err;
            v.chk_rdata = !v.wen;
            v.exp_rdata = ref_read(v.addr);
            run_op(v, $sformatf("rnd%0d", k));
        end

        check("final debug_state", 64'(debug_state), 64'd0);
        check("final debug_visit_times", 64'(debug_visit_times), DBG ? 64'(n_done) : 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
